arb4_penc_ctrl: RTL

- Four-requester arbiter that shares one resource using 4-to-2 priority encoding; req[3] has the highest priority.
- Registers the encoded winner as a one-hot grant plus a 2-bit index.
- Holds the grant until the owner releases its request, then inserts a one-cycle idle gap.
- Sits between requesting blocks and the shared resource's select input.

---
 rtl/arb4_penc_pkg.sv | 25 ++
 rtl/arb4_penc_ctrl_penc.sv | 25 ++
 rtl/arb4_penc_ctrl.sv | 128 ++++++++++++
 3 files changed

// File: rtl/arb4_penc_pkg.sv
// ---------------------------------------------------------------------------
// arb4_penc_pkg : shared state encodings, sizes and helpers for arb4_penc_ctrl
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package arb4_penc_pkg;

  localparam int C_NREQ         = 4;
  localparam int C_IDX_W        = 2;
  localparam int C_HOLD_MAX_DEF = 15;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_GRANT = 2'b01,
    ST_GAP   = 2'b10
  } state_t;

  function automatic logic [C_NREQ-1:0] f_onehot(input logic [C_IDX_W-1:0] idx);
    return 4'b0001 << idx;
  endfunction

endpackage

`default_nettype wire

// File: rtl/arb4_penc_ctrl_penc.sv
// ---------------------------------------------------------------------------
// arb_penc4 : 4-to-2 priority encoder, bit 3 highest, valid when any bit set
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module arb_penc4
  import arb4_penc_pkg::*;
(
  input  logic [C_NREQ-1:0]  i_req,
  output logic [C_IDX_W-1:0] o_idx,
  output logic               o_vld
);

  always_comb begin
    o_vld = |i_req;
    o_idx = 2'b00;
    if (i_req[3])      o_idx = 2'b11;
    else if (i_req[2]) o_idx = 2'b10;
    else if (i_req[1]) o_idx = 2'b01;
  end

endmodule

`default_nettype wire

// File: rtl/arb4_penc_ctrl.sv
// ---------------------------------------------------------------------------
// arb4_penc_ctrl : 4-requester non-preemptive priority arbiter with idle gap.
// Optional hold timeout with requester masking: ARB4_PENC_TIMEOUT_EN
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module arb4_penc_ctrl
  import arb4_penc_pkg::*;
#(
  parameter int HOLD_MAX = C_HOLD_MAX_DEF,
  parameter int CNT_W    = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [C_NREQ-1:0]  req,
  output logic [C_NREQ-1:0]  gnt,
  output logic [C_IDX_W-1:0] gnt_id,
  output logic               gnt_vld,
  output logic               busy,
  output logic               tout
);

  state_t               r_state, w_state_nxt;
  logic [C_NREQ-1:0]    r_gnt, w_gnt_nxt;
  logic [C_IDX_W-1:0]   r_gnt_id, w_gnt_id_nxt;
  logic                 r_tout, w_tout_nxt;
  logic [C_NREQ-1:0]    w_mask;
  logic [C_NREQ-1:0]    w_m;
  logic [C_IDX_W-1:0]   w_idx;
  logic                 w_vld;
  logic                 w_hold_hit;

  assign w_m = req & ~w_mask;

  arb_penc4 u_penc (
    .i_req (w_m),
    .o_idx (w_idx),
    .o_vld (w_vld)
  );

`ifdef ARB4_PENC_TIMEOUT_EN
  logic [CNT_W-1:0]  r_cnt;
  logic [C_NREQ-1:0] r_mask;
  logic              w_issue;
  logic              w_timeout;

  assign w_issue    = (r_state == ST_IDLE) && w_vld;
  assign w_hold_hit = ((r_cnt + CNT_W'(1)) == CNT_W'(HOLD_MAX));
  assign w_timeout  = (r_state == ST_GRANT) && req[r_gnt_id] && w_hold_hit;
  assign w_mask     = r_mask;

  // r_cnt counts completed GRANT cycles of the current owner
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt  <= '0;
      r_mask <= '0;
    end else begin
      if (w_issue)                  r_cnt <= '0;
      else if (r_state == ST_GRANT) r_cnt <= r_cnt + CNT_W'(1);

      if (w_timeout)                r_mask <= r_mask | f_onehot(r_gnt_id);
      else if (w_issue)             r_mask <= '0;
      else if ((r_state == ST_IDLE) && (r_mask != '0)) r_mask <= '0;
    end
  end
`else
  assign w_hold_hit = 1'b0;
  assign w_mask     = '0;
`endif

  always_comb begin
    w_state_nxt  = r_state;
    w_gnt_nxt    = r_gnt;
    w_gnt_id_nxt = r_gnt_id;
    w_tout_nxt   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_vld) begin
          w_state_nxt  = ST_GRANT;
          w_gnt_nxt    = f_onehot(w_idx);
          w_gnt_id_nxt = w_idx;
        end
      end
      ST_GRANT: begin
        // gnt_id is deliberately kept on release so the last owner stays visible
        if (!req[r_gnt_id]) begin
          w_state_nxt = ST_GAP;
          w_gnt_nxt   = '0;
        end else if (w_hold_hit) begin
          w_state_nxt = ST_GAP;
          w_gnt_nxt   = '0;
          w_tout_nxt  = 1'b1;
        end
      end
      ST_GAP: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_gnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_gnt    <= '0;
      r_gnt_id <= '0;
      r_tout   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_gnt    <= w_gnt_nxt;
      r_gnt_id <= w_gnt_id_nxt;
      r_tout   <= w_tout_nxt;
    end
  end

  assign gnt     = r_gnt;
  assign gnt_id  = r_gnt_id;
  assign gnt_vld = |r_gnt;
  assign busy    = (r_state != ST_IDLE);
  assign tout    = r_tout;

endmodule

`default_nettype wire
